// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: field polynomial, generator taps,
// encoder state encodings and a GF(2^8) doubling helper.
package rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int RS_NPAR = 4;

  localparam logic [7:0] RS_G0 = 8'h40;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G3 = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b100
  } state_e;

  function automatic logic [7:0] gf_xtime(
    input logic [7:0] v
  );
    return {v[6:0], 1'b0}
         ^ (v[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

endpackage

// File: rtl/gf2m8_multi.sv
// GF(2^8) multiplier over 0x11D, purely combinational
// shift-and-add with no pipeline stage.
module gf2m8_multi
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    y = acc;
  end

endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic RS(K+4,K) encoder over GF(2^8): forwards K message
// bytes, then appends 4 parity bytes from a Galois LFSR.
module rs_enc_lfsr
  import rs_pkg::*;
#(
  parameter int K  = 251,
  parameter int CW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy
);

  localparam logic [CW-1:0] KLAST = CW'(K);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [1:0]    PLAST = 2'(RS_NPAR - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pcnt_q, pcnt_d;
  logic [7:0]    p0_q, p0_d;
  logic [7:0]    p1_q, p1_d;
  logic [7:0]    p2_q, p2_d;
  logic [7:0]    p3_q, p3_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;

  logic       out_free;
  logic       in_fire;
  logic [7:0] fb;
  logic [7:0] m0, m1, m2, m3;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q != ST_PARITY) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign fb       = in_data ^ p3_q;

  gf2m8_multi u_m0 (.a(fb), .b(RS_G0), .y(m0));
  gf2m8_multi u_m1 (.a(fb), .b(RS_G1), .y(m1));
  gf2m8_multi u_m2 (.a(fb), .b(RS_G2), .y(m2));
  gf2m8_multi u_m3 (.a(fb), .b(RS_G3), .y(m3));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end

    unique case (1'b1)
      (state_q == ST_PARITY): begin
        // drain the LFSR highest degree first
        if (out_free) begin
          out_data_d  = p3_q;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = (pcnt_q == PLAST);
          p3_d        = p2_q;
          p2_d        = p1_q;
          p1_d        = p0_q;
          p0_d        = '0;
          pcnt_d      = pcnt_q + 2'd1;
          if (pcnt_q == PLAST) state_d = ST_IDLE;
        end
      end
      (state_q == ST_IDLE),
      (state_q == ST_DATA): begin
        if (in_fire) begin
          p3_d        = p2_q ^ m3;
          p2_d        = p1_q ^ m2;
          p1_d        = p0_q ^ m1;
          p0_d        = m0;
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_sop_d   = (state_q == ST_IDLE);
          out_eop_d   = 1'b0;
          cnt_d = (state_q == ST_IDLE) ? ONE
                                       : cnt_q + ONE;
          if (cnt_d == KLAST) begin
            state_d = ST_PARITY;
            pcnt_d  = '0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Bench for rs_enc_lfsr: K=4 and K=251 encoders against a polynomial
// long-division model, syndrome evaluation, stalls and mid-word reset.
module tb_rs_enc_lfsr;

  localparam int KA = 4;
  localparam int KB = 251;

  typedef struct {
    logic [31:0] msg;
    logic [31:0] par;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } cap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [1:0] out_sop;
  logic [1:0] out_eop;
  logic [1:0] busy;
  logic [7:0] in_data [2];
  logic [7:0] out_data [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_viol = 0;
  int irp_viol = 0;
  int busy_viol = 0;

  logic [1:0] bp = 2'b00;
  logic [7:0] buf_m [256];
  logic [7:0] par [4];
  cap_t       cap0 [$];
  cap_t       cap1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  logic       held [2];
  logic [7:0] hd [2];
  logic [1:0] hf [2];
  logic       pend [2];
  int         acc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs_enc_lfsr #(.K(KA), .CW(8)) u_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .out_sop   (out_sop[0]),
    .out_eop   (out_eop[0]),
    .busy      (busy[0])
  );

  rs_enc_lfsr #(.K(KB), .CW(8)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .out_sop   (out_sop[1]),
    .out_eop   (out_eop[1]),
    .busy      (busy[1])
  );

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // generator built from its roots, parity by schoolbook division
  function automatic void model(input int k);
    logic [7:0] g [5];
    logic [7:0] d [260];
    logic [7:0] rt;
    logic [7:0] c;
    g[0] = 8'h01;
    for (int i = 1; i < 5; i++) g[i] = 8'h00;
    rt = 8'h01;
    for (int r = 0; r < 4; r++) begin
      for (int i = 4; i > 0; i--)
        g[i] = g[i-1] ^ gmul(g[i], rt);
      g[0] = gmul(g[0], rt);
      rt = gmul(rt, 8'h02);
    end
    for (int i = 0; i < k + 4; i++)
      d[i] = (i < k) ? buf_m[i] : 8'h00;
    for (int i = 0; i < k; i++) begin
      c = d[i];
      for (int j = 1; j <= 4; j++)
        d[i+j] = d[i+j] ^ gmul(c, g[4-j]);
    end
    for (int j = 0; j < 4; j++) par[j] = d[k+j];
  endfunction

  function automatic int kk(input int s);
    return (s != 0) ? KB : KA;
  endfunction

  function automatic int qsize(input int s);
    return (s != 0) ? cap1.size() : cap0.size();
  endfunction

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp_v
  );
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp_v, exp_v);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int s);
    int k;
    k = kk(s);
    model(k);
    for (int i = 0; i < k + 4; i++) begin
      if (s != 0) exp1.push_back(i < k ? buf_m[i] : par[i-k]);
      else        exp0.push_back(i < k ? buf_m[i] : par[i-k]);
    end
  endtask

  task automatic send_bytes(
    input int s,
    input int n,
    input int gap
  );
    int w;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap) begin
        in_valid[s] = 1'b0;
        in_data[s]  = 8'($urandom);
        sync();
      end
      in_valid[s] = 1'b1;
      in_data[s]  = buf_m[i];
      w = 0;
      @(negedge clk);
      while (!in_ready[s] && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: dut %0d byte %0d not accepted", s, i);
        in_valid[s] = 1'b0;
        return;
      end
      sync();
    end
    in_valid[s] = 1'b0;
    in_data[s]  = 8'($urandom);
  endtask

  task automatic drain(input int s, input int n);
    int w;
    w = 0;
    while ((qsize(s) < n || busy[s]) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d bytes expected %0d", qsize(s), n);
    end
  endtask

  task automatic check_cws(input int s, input int n);
    int         k;
    int         bad;
    int         fr;
    int         sb;
    cap_t       e;
    logic [7:0] x;
    logic [7:0] rt;
    logic [7:0] sy;
    logic [7:0] cw [260];
    k = kk(s);
    chk("cap_count", qsize(s), n * (k + 4));
    if (qsize(s) != n * (k + 4)) begin
      if (s != 0) begin cap1.delete(); exp1.delete(); end
      else        begin cap0.delete(); exp0.delete(); end
      return;
    end
    for (int c = 0; c < n; c++) begin
      bad = 0;
      fr  = 0;
      for (int i = 0; i < k + 4; i++) begin
        if (s != 0) begin e = cap1.pop_front(); x = exp1.pop_front(); end
        else        begin e = cap0.pop_front(); x = exp0.pop_front(); end
        cw[i] = e.d;
        if (e.d !== x) bad++;
        if (e.sop !== (i == 0) || e.eop !== (i == k + 3)) fr++;
      end
      chk("cw_data", bad, 0);
      chk("cw_frame", fr, 0);
      sb = 0;
      rt = 8'h01;
      for (int j = 0; j < 4; j++) begin
        sy = 8'h00;
        for (int i = 0; i < k + 4; i++) sy = gmul(sy, rt) ^ cw[i];
        if (sy != 8'h00) sb++;
        rt = gmul(rt, 8'h02);
      end
      chk("cw_syndrome", sb, 0);
    end
  endtask

  task automatic mon(input int s);
    cap_t e;
    if (rst) begin
      held[s] = 1'b0;
      pend[s] = 1'b0;
      acc[s]  = 0;
      return;
    end
    if (held[s] && (!out_valid[s] || out_data[s] !== hd[s]
        || {out_sop[s], out_eop[s]} !== hf[s]))
      stall_viol++;
    held[s] = out_valid[s] && !out_ready[s];
    hd[s]   = out_data[s];
    hf[s]   = {out_sop[s], out_eop[s]};
    if (pend[s] && !(out_valid[s] && out_eop[s]) && in_ready[s])
      irp_viol++;
    if ((out_valid[s] || pend[s]) && !busy[s]) busy_viol++;
    if (out_valid[s] && out_eop[s]) pend[s] = 1'b0;
    if (in_valid[s] && in_ready[s]) begin
      acc[s]++;
      if (acc[s] == kk(s)) begin
        acc[s]  = 0;
        pend[s] = 1'b1;
      end
    end
    if (out_valid[s] && out_ready[s]) begin
      e.cyc = cyc;
      e.sop = out_sop[s];
      e.eop = out_eop[s];
      e.d   = out_data[s];
      if (s != 0) cap1.push_back(e);
      else        cap0.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) mon(s);
    end
  end

  initial begin
    out_ready = 2'b11;
    forever begin
      sync();
      for (int s = 0; s < 2; s++)
        out_ready[s] = bp[s] ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [4];
    int   n;
    vt[0] = '{msg: 32'h0000_0001, par: 32'h0F36_7840};
    vt[1] = '{msg: 32'h0000_0000, par: 32'h0000_0000};
    vt[2] = '{msg: 32'h0000_0100, par: 32'h6357_D2E7};
    vt[3] = '{msg: 32'h0000_0101, par: 32'h6C61_AAA7};

    rst         = 1'b1;
    in_valid    = 2'b00;
    in_data[0]  = 8'h00;
    in_data[1]  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++)
      chk("reset_state",
          int'({out_valid[s], out_sop[s], out_eop[s],
                busy[s], in_ready[s], out_data[s]}),
          int'(13'h0100));

    // table vectors back to back at full rate on K=4
    sync();
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++)
        buf_m[i] = vt[v].msg[31-8*i -: 8];
      for (int i = 0; i < 4; i++) exp0.push_back(buf_m[i]);
      for (int i = 0; i < 4; i++)
        exp0.push_back(vt[v].par[31-8*i -: 8]);
      send_bytes(0, KA, 0);
    end
    drain(0, 32);
    if (cap0.size() >= 32)
      chk("b2b_span", cap0[31].cyc - cap0[0].cyc, 31);
    check_cws(0, 4);

    // all-zero K=251 codeword
    sync();
    for (int i = 0; i < KB; i++) buf_m[i] = 8'h00;
    push_model(1);
    send_bytes(1, KB, 0);
    drain(1, KB + 4);
    check_cws(1, 1);

    // reset after byte 100 of a K=251 codeword
    sync();
    for (int i = 0; i < KB; i++) buf_m[i] = 8'($urandom);
    send_bytes(1, 100, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_state",
        int'({out_valid[1], out_sop[1], out_eop[1],
              busy[1], in_ready[1], out_data[1]}),
        int'(13'h0100));
    n = 0;
    foreach (cap1[i]) if (cap1[i].eop) n++;
    chk("rst_no_eop", n, 0);
    sync();
    rst = 1'b0;
    cap1.delete();
    for (int i = 0; i < KB; i++) buf_m[i] = 8'($urandom);
    push_model(1);
    send_bytes(1, KB, 0);
    drain(1, KB + 4);
    check_cws(1, 1);

    // random messages with stalls on both sides, K=4
    bp = 2'b01;
    sync();
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < KA; i++) buf_m[i] = 8'($urandom);
      push_model(0);
      send_bytes(0, KA, 30);
    end
    drain(0, 150 * (KA + 4));
    check_cws(0, 150);

    // random messages with stalls, K=251
    bp = 2'b10;
    sync();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < KB; i++) buf_m[i] = 8'($urandom);
      push_model(1);
      send_bytes(1, KB, 30);
    end
    drain(1, 4 * (KB + 4));
    check_cws(1, 4);
    bp = 2'b00;

    chk("stall_stable", stall_viol, 0);
    chk("in_ready_parity", irp_viol, 0);
    chk("busy_flag", busy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
